// File: rtl/puf_ctrl_pkg.sv
// Shared types, default parameters and the pair-select rule for the RO-PUF evaluation controller.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEF_RESP_BITS = 8;
  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_SETTLE    = 4;
  localparam int DEF_MARGIN    = 16;
  localparam int DEF_CW        = 16;

  // Offsets both bases by idx; a colliding B index is bumped so a pair never compares an oscillator with itself.
  function automatic logic [7:0] pair_sel(input logic [3:0] base_a, input logic [3:0] base_b,
                                          input logic [3:0] idx);
    logic [3:0] a;
    logic [3:0] b;
    a = base_a + idx;
    b = base_b + idx;
    if (a == b) begin
      b = a + 4'd1;
    end else begin
      b = b;
    end
    return {a, b};
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter with a zero flag; times both the RUN window and the SETTLE gap.
module puf_window_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] cnt_r;

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_r <= {TW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {TW{1'b0}})) begin
      cnt_r <= cnt_r - {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (cnt_r == {TW{1'b0}});

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequences one timed oscillator-pair evaluation per response bit and collects the response word.
// rst_n is an active-high asynchronous reset in this codebase.
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int RESP_BITS = DEF_RESP_BITS,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int MARGIN    = DEF_MARGIN,
  parameter int CW        = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           challenge,
  output logic [3:0]           sel_a,
  output logic [3:0]           sel_b,
  output logic                 osc_en,
  output logic                 cnt_clr,
  input  logic [CW-1:0]        count_a,
  input  logic [CW-1:0]        count_b,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] unreliable
);

  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state_r;
  logic [3:0]    idx_r;
  logic [7:0]    ch_r;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_dec_s;
  logic          tmr_zero_s;
  logic [CW:0]   diff_s;
  logic          gt_s;
  logic          unrel_s;
  logic          last_s;

  puf_window_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Timer control: CLEAR arms the window, the last RUN cycle re-arms for the settle gap.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    tmr_dec_s  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = TW'(WINDOW - 1);
      end
      ST_RUN: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TW'(SETTLE - 1);
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_SETTLE: tmr_dec_s = 1'b1;
      default:   tmr_dec_s = 1'b0;
    endcase
  end

  // Bit decision: widened difference so a large spread never wraps below the margin.
  always_comb begin
    gt_s = (count_a > count_b);
    if (gt_s) begin
      diff_s = {1'b0, count_a} - {1'b0, count_b};
    end else begin
      diff_s = {1'b0, count_b} - {1'b0, count_a};
    end
    unrel_s = (diff_s < (CW+1)'(MARGIN)) || (&count_a) || (&count_b) || (count_a == count_b);
    last_s  = (idx_r == 4'(RESP_BITS - 1));
  end

  // Main sequencer with registered outputs; abort outranks start and the DONE handshake.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      ch_r       <= 8'd0;
      sel_a      <= 4'd0;
      sel_b      <= 4'd0;
      osc_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= {RESP_BITS{1'b0}};
      unreliable <= {RESP_BITS{1'b0}};
    end else if (abort && (state_r != ST_IDLE)) begin
      state_r    <= ST_IDLE;
      osc_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= {RESP_BITS{1'b0}};
      unreliable <= {RESP_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            ch_r           <= challenge;
            idx_r          <= 4'd0;
            response       <= {RESP_BITS{1'b0}};
            unreliable     <= {RESP_BITS{1'b0}};
            {sel_a, sel_b} <= pair_sel(challenge[3:0], challenge[7:4], 4'd0);
            cnt_clr        <= 1'b1;
            busy           <= 1'b1;
            state_r        <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_clr <= 1'b0;
          osc_en  <= 1'b1;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (tmr_zero_s) begin
            osc_en  <= 1'b0;
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero_s) begin
            state_r <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          for (int i = 0; i < RESP_BITS; i++) begin
            if (idx_r == 4'(i)) begin
              response[i]   <= gt_s;
              unreliable[i] <= unrel_s;
            end
          end
          if (last_s) begin
            resp_valid <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            idx_r          <= idx_r + 4'd1;
            {sel_a, sel_b} <= pair_sel(ch_r[3:0], ch_r[7:4], idx_r + 4'd1);
            cnt_clr        <= 1'b1;
            state_r        <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          osc_en     <= 1'b0;
          cnt_clr    <= 1'b0;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Randomized self-checking bench for puf_eval_ctrl against an oscillator-array reference model.
module tb_puf_eval_ctrl;

  localparam int RB = 4;
  localparam int WIN = 16;
  localparam int SET = 2;
  localparam int MRG = 16;
  localparam int BIT_CYC = WIN + SET + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, resp_ready;
  logic [7:0]  challenge;
  logic [3:0]  sel_a, sel_b;
  logic        osc_en, cnt_clr, busy, resp_valid;
  logic [15:0] count_a, count_b;
  logic [RB-1:0] response, unreliable;

  logic        fixed_mode;
  logic [15:0] fix_a, fix_b;
  logic [15:0] freq [16];
  logic [RB-1:0] exp_resp, exp_unrel;
  int n_chk = 0;
  int n_pass = 0;

  puf_eval_ctrl #(.RESP_BITS(RB), .WINDOW(WIN), .SETTLE(SET), .MARGIN(MRG), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .challenge(challenge),
    .sel_a(sel_a), .sel_b(sel_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
    .count_a(count_a), .count_b(count_b), .busy(busy), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .response(response), .unreliable(unreliable)
  );

  always #5 clk = ~clk;

  // Counter datapath stand-in: either fixed counts or the count of whichever oscillator is selected.
  always_comb begin
    if (fixed_mode) begin
      count_a = fix_a;
      count_b = fix_b;
    end else begin
      count_a = freq[sel_a];
      count_b = freq[sel_b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_pair(input logic [7:0] ch, input int i);
    int a, b;
    a = (int'(ch[3:0]) + i) % 16;
    b = (int'(ch[7:4]) + i) % 16;
    if (a == b) b = (a + 1) % 16;
    return {a[3:0], b[3:0]};
  endfunction

  task automatic rand_freq();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 7) == 0) freq[i] = 16'hFFFF;
      else freq[i] = 16'($urandom_range(0, 400));
    end
  endtask

  // mode 0: full run, 1: abort at edge 30, 2: async reset at edge 10
  task automatic run_eval(input logic [7:0] ch, input int mode);
    int k, nclr, osc_cyc, ca, cb, d;
    logic [7:0] p;
    bit done;
    for (int i = 0; i < RB; i++) begin
      p = exp_pair(ch, i);
      ca = fixed_mode ? int'(fix_a) : int'(freq[p[7:4]]);
      cb = fixed_mode ? int'(fix_b) : int'(freq[p[3:0]]);
      d = (ca > cb) ? ca - cb : cb - ca;
      exp_resp[i]  = (ca > cb);
      exp_unrel[i] = (d < MRG) || (ca == 65535) || (cb == 65535);
    end
    challenge = ch;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; nclr = 0; osc_cyc = 0; done = 1'b0;
    while (!done && k < 200) begin
      if (cnt_clr) begin
        chk("clr_edge", k, BIT_CYC * nclr);
        p = exp_pair(ch, nclr);
        chk("clr_sel_a", sel_a, p[7:4]);
        chk("clr_sel_b", sel_b, p[3:0]);
        nclr++;
      end
      if (osc_en) begin
        osc_cyc++;
        p = exp_pair(ch, nclr - 1);
        chk("run_sel_a", sel_a, p[7:4]);
        chk("run_sel_b", sel_b, p[3:0]);
      end
      if (mode == 1 && k == 30) begin
        chk("abort_pre_osc", osc_en, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_osc", osc_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", resp_valid, 0);
        chk("abort_resp", response, 0);
        chk("abort_unrel", unreliable, 0);
        done = 1'b1;
      end else if (mode == 2 && k == 10) begin
        chk("rst_pre_osc", osc_en, 1);
        rst_n = 1'b1;
        #1;
        chk("rst_osc", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_clr", cnt_clr, 0);
        done = 1'b1;
      end else if (resp_valid) begin
        chk("valid_edge", k, RB * BIT_CYC);
        chk("osc_cycles", osc_cyc, RB * WIN);
        chk("response", response, exp_resp);
        chk("unreliable", unreliable, exp_unrel);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  task automatic handshake(input int hold);
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      @(posedge clk); #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_resp", response, exp_resp);
      chk("bp_unrel", unreliable, exp_unrel);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hs_valid", resp_valid, 0);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; resp_ready = 1'b0; challenge = 8'h00;
    fixed_mode = 1'b1; fix_a = 16'd200; fix_b = 16'd100;
    for (int i = 0; i < 16; i++) freq[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", {sel_a, sel_b}, 0);
    chk("rst_osc_en", osc_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_valid0", resp_valid, 0);
    chk("rst_resp", {response, unreliable}, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    run_eval(8'h31, 0);
    chk("nom_resp", response, 4'b1111);
    chk("nom_unrel", unreliable, 4'b0000);
    handshake(10);

    fixed_mode = 1'b0;
    rand_freq();
    run_eval(8'hFF, 0);
    handshake(0);
    run_eval(8'h55, 0);
    handshake(1);

    for (int i = 0; i < 16; i++) freq[i] = 16'd50;
    freq[0] = 16'd100; freq[8]  = 16'd100;
    freq[1] = 16'd120; freq[9]  = 16'd110;
    freq[2] = 16'hFFFF; freq[10] = 16'd5;
    freq[3] = 16'd50;  freq[11] = 16'd300;
    run_eval(8'h80, 0);
    chk("rel_resp", response, 4'b0110);
    chk("rel_unrel", unreliable, 4'b0111);
    handshake(2);

    rand_freq();
    run_eval(8'($urandom), 1);
    run_eval(8'($urandom), 0);
    handshake(0);

    run_eval(8'($urandom), 2);
    run_eval(8'($urandom), 0);
    handshake(1);

    repeat (6) begin
      rand_freq();
      run_eval(8'($urandom), 0);
      handshake($urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
